// File: rtl/parity_asm_pkg.sv
// Shared types and defaults for the serial parity checker.
package parity_asm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/parity_asm_datapath.sv
// Datapath for parity_asm: shift register, serial-out flop, parity accumulator and bit counter.
module parity_asm_datapath
    import parity_asm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             load_en_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] reg_o,
    output logic             serial_o,
    output logic             parity_o,
    output logic             last_bit_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] reg_q, reg_d;
    logic             serial_q, serial_d;
    logic             parity_q, parity_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        reg_d    = reg_q;
        serial_d = serial_q;
        parity_d = parity_q;
        count_d  = count_q;
        if (load_en_i) begin
            reg_d    = data_i;
            serial_d = 1'b0;
            parity_d = 1'b0;
            count_d  = '0;
        end else if (shift_en_i) begin
            reg_d    = {1'b0, reg_q[WIDTH-1:1]};
            serial_d = reg_q[0];
            parity_d = parity_q ^ reg_q[0];
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            reg_q    <= '0;
            serial_q <= 1'b0;
            parity_q <= 1'b0;
            count_q  <= '0;
        end else begin
            reg_q    <= reg_d;
            serial_q <= serial_d;
            parity_q <= parity_d;
            count_q  <= count_d;
        end
    end

    // High while the WIDTH-th shift is pending, so the controller leaves SHIFT on that edge.
    assign last_bit_o = (count_q == LAST_CNT);
    assign reg_o      = reg_q;
    assign serial_o   = serial_q;
    assign parity_o   = parity_q;

endmodule

// File: rtl/parity_asm.sv
// Serial parity checker (ASM): controller state machine driving the shift/parity datapath.
module parity_asm
    import parity_asm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dataA,
    output logic             serialout,
    output logic             parity,
    output logic [WIDTH-1:0] registerA
);

    state_t state_q, state_d;
    logic   load_en;
    logic   shift_en;
    logic   last_bit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SHIFT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                SHIFT:   state_d = last_bit ? DONE : SHIFT;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_en  = load;
        shift_en = 1'b0;
        if (!load && (state_q == SHIFT)) begin
            shift_en = 1'b1;
        end
    end

    parity_asm_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock_i    (clock),
        .reset_n_i  (reset_n),
        .load_en_i  (load_en),
        .shift_en_i (shift_en),
        .data_i     (dataA),
        .reg_o      (registerA),
        .serial_o   (serialout),
        .parity_o   (parity),
        .last_bit_o (last_bit)
    );

endmodule

// File: tb/tb_parity_asm.sv
// Self-checking bench for parity_asm against a word/shift-count reference model.
module tb_parity_asm;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic         load;
    logic [W-1:0] dataA;
    logic         serialout;
    logic         parity;
    logic [W-1:0] registerA;

    int checks = 0;
    int errors = 0;

    // Model: the loaded word and how many of its bits have been shifted out.
    int unsigned m_word = 0;
    int unsigned m_k    = 0;
    bit          m_active = 0;

    parity_asm #(
        .WIDTH (W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .dataA     (dataA),
        .serialout (serialout),
        .parity    (parity),
        .registerA (registerA)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W-1:0] exp_reg();
        return W'(m_word >> m_k);
    endfunction

    function automatic logic exp_serial();
        if (m_k == 0) return 1'b0;
        return logic'((m_word >> (m_k - 1)) & 1);
    endfunction

    function automatic logic exp_parity();
        int unsigned ones = 0;
        for (int unsigned i = 0; i < m_k; i++) ones += (m_word >> i) & 1;
        return logic'(ones % 2);
    endfunction

    task automatic model_reset();
        m_word = 0;
        m_k = 0;
        m_active = 0;
    endtask

    task automatic tick(input logic ld, input logic [W-1:0] d);
        load  = ld;
        dataA = d;
        @(posedge clock);
        #1;
        if (ld) begin
            m_word = int'(d);
            m_k = 0;
            m_active = 1;
        end else if (m_active && m_k < W) begin
            m_k++;
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load = 1'b0;
        dataA = '0;
        model_reset();
        #1;
        checks++;
        if (registerA !== 8'h00 || parity !== 1'b0 || serialout !== 1'b0) begin
            errors++;
            $display("FAIL reset_async reg=%h par=%b ser=%b want 00/0/0", registerA, parity, serialout);
        end
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h5A);
            checks++;
            if (registerA !== 8'h00 || parity !== 1'b0 || serialout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d reg=%h par=%b ser=%b want 00/0/0", i, registerA, parity, serialout);
            end
        end
    endtask

    task automatic test_nominal();
        logic [W-1:0] reg_tab [0:8];
        logic         ser_tab [1:8];
        reg_tab = '{8'hEA, 8'h75, 8'h3A, 8'h1D, 8'h0E, 8'h07, 8'h03, 8'h01, 8'h00};
        ser_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tick(1'b1, 8'b11101010);
        checks++;
        if (registerA !== reg_tab[0] || serialout !== 1'b0 || parity !== 1'b0) begin
            errors++;
            $display("FAIL nominal_load reg=%h ser=%b par=%b want %h/0/0", registerA, serialout, parity, reg_tab[0]);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, $urandom);
            checks++;
            if (registerA !== reg_tab[i] || serialout !== ser_tab[i] || parity !== exp_parity()) begin
                errors++;
                $display("FAIL nominal_shift%0d reg=%h ser=%b par=%b want %h/%b/%b",
                         i, registerA, serialout, parity, reg_tab[i], ser_tab[i], exp_parity());
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, $urandom);
            checks++;
            if (parity !== 1'b1 || registerA !== 8'h00 || serialout !== 1'b1) begin
                errors++;
                $display("FAIL nominal_hold%0d par=%b reg=%h ser=%b want 1/00/1", i, parity, registerA, serialout);
            end
        end
    endtask

    task automatic test_even_count();
        tick(1'b1, 8'hFF);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, $urandom);
            checks++;
            if (serialout !== 1'b1 || registerA !== exp_reg() || parity !== exp_parity()) begin
                errors++;
                $display("FAIL even_shift%0d ser=%b reg=%h par=%b want 1/%h/%b",
                         i, serialout, registerA, parity, exp_reg(), exp_parity());
            end
        end
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL even_final par=%b want 0", parity);
        end
    endtask

    task automatic test_restart();
        tick(1'b1, 8'h01);
        repeat (3) tick(1'b0, $urandom);
        checks++;
        if (parity !== 1'b1 || registerA !== 8'h00) begin
            errors++;
            $display("FAIL restart_pre par=%b reg=%h want 1/00", parity, registerA);
        end
        tick(1'b1, 8'h03);
        checks++;
        if (parity !== 1'b0 || serialout !== 1'b0 || registerA !== 8'h03) begin
            errors++;
            $display("FAIL restart_load par=%b ser=%b reg=%h want 0/0/03", parity, serialout, registerA);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, $urandom);
            checks++;
            if (parity !== exp_parity() || registerA !== exp_reg() || serialout !== exp_serial()) begin
                errors++;
                $display("FAIL restart_shift%0d par=%b reg=%h ser=%b want %b/%h/%b",
                         i, parity, registerA, serialout, exp_parity(), exp_reg(), exp_serial());
            end
        end
        checks++;
        if (parity !== 1'b0 || serialout !== 1'b0) begin
            errors++;
            $display("FAIL restart_final par=%b ser=%b want 0/0", parity, serialout);
        end
    endtask

    task automatic test_reset_mid_shift();
        tick(1'b1, 8'hEA);
        repeat (4) tick(1'b0, $urandom);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (registerA !== 8'h00 || parity !== 1'b0 || serialout !== 1'b0) begin
            errors++;
            $display("FAIL midreset reg=%h par=%b ser=%b want 00/0/0", registerA, parity, serialout);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        tick(1'b0, $urandom);
        checks++;
        if (registerA !== 8'h00 || parity !== 1'b0 || serialout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle reg=%h par=%b ser=%b want 00/0/0", registerA, parity, serialout);
        end
        tick(1'b1, 8'h80);
        repeat (8) tick(1'b0, $urandom);
        checks++;
        if (parity !== 1'b1 || serialout !== 1'b1 || registerA !== 8'h00) begin
            errors++;
            $display("FAIL midreset_reload par=%b ser=%b reg=%h want 1/1/00", parity, serialout, registerA);
        end
    endtask

    task automatic test_x_idle();
        reset_n = 1'b0;
        model_reset();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 'x);
            checks++;
            if ($isunknown({registerA, parity, serialout}) || registerA !== 8'h00 || parity !== 1'b0) begin
                errors++;
                $display("FAIL x_idle%0d reg=%h par=%b ser=%b want 00/0/0", i, registerA, parity, serialout);
            end
        end
        tick(1'b1, 8'h6B);
        repeat (10) tick(1'b0, 'x);
        checks++;
        if ($isunknown({registerA, parity, serialout}) || parity !== exp_parity() || serialout !== exp_serial()) begin
            errors++;
            $display("FAIL x_done reg=%h par=%b ser=%b want 00/%b/%b", registerA, parity, serialout,
                     exp_parity(), exp_serial());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 7) == 0, W'($urandom));
            checks++;
            if (registerA !== exp_reg() || serialout !== exp_serial() || parity !== exp_parity()) begin
                errors++;
                $display("FAIL random%0d reg=%h ser=%b par=%b want %h/%b/%b word=%h k=%0d",
                         i, registerA, serialout, parity, exp_reg(), exp_serial(), exp_parity(), m_word, m_k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_even_count();
        test_restart();
        test_reset_mid_shift();
        test_x_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
